// File: rtl/rtc_seg_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : rtc_seg_scanner_if
// Description : Bundle between the RTC time digits / display and the
//               7-segment scanner.
//               master : drives the enable, blanking and BCD digits, and
//                        observes the display outputs (RTC side / bench)
//               slave  : the scanner itself
//               Members:
//                 en, lz_blank               scan enable, hours-tens blanking
//                 hrm,hrl,minm,minl,secm,secl BCD time digits (4 bits each)
//                 seg[6:0] {g..a}, dp, an[5:0] display drive
//                 frame_done, bcd_err        frame pulse, sticky range error
// Revision    : 1.0 - initial release
// ============================================================================
interface rtc_seg_scanner_if;
  logic       en;
  logic       lz_blank;
  logic [3:0] hrm;
  logic [3:0] hrl;
  logic [3:0] minm;
  logic [3:0] minl;
  logic [3:0] secm;
  logic [3:0] secl;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame_done;
  logic       bcd_err;

  modport master (
    output en, lz_blank, hrm, hrl, minm, minl, secm, secl,
    input  seg, dp, an, frame_done, bcd_err
  );

  modport slave (
    input  en, lz_blank, hrm, hrl, minm, minl, secm, secl,
    output seg, dp, an, frame_done, bcd_err
  );
endinterface
`default_nettype wire

// File: rtl/rtc_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module      : rtc_seg_scanner
// Description : Snapshots the six RTC BCD digits once per frame and scans
//               them onto a 6-digit 7-segment display, one digit per slot of
//               DWELL_TICKS cycles, with decode, hours-tens leading-zero
//               blanking and per-digit range checking (dash + sticky error).
//               All display outputs are registered.
// Ports       : hundred_clk - scan clock
//               rst         - asynchronous, active-high reset
//               bus         - rtc_seg_scanner_if.slave (digits in, display out)
// Parameters  : DWELL_TICKS    - cycles per digit slot (>= 1)
//               SEG_ACTIVE_LOW - 1: seg/dp active-low, 0: active-high
//               AN_ACTIVE_LOW  - 1: an active-low, 0: active-high
// Options     : RTC_SEG_BLINK_EN - when defined, the hh.mm.ss separators
//               light only while the snapshotted secl is even (0.5 Hz blink)
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_seg_scanner #(
  parameter int DWELL_TICKS    = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  wire               hundred_clk,
  input  wire               rst,
  rtc_seg_scanner_if.slave  bus
);

  localparam int             DWELL_W    = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_TICKS - 1);
  localparam logic [2:0]     IDX_LAST   = 3'd5;
  localparam logic [6:0]     SEG_DASH   = 7'h40;
  // XOR masks: applying them to an active-high value yields the pin level,
  // and they are also the "all off" pin levels.
  localparam logic [6:0]     SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic           DP_OFF     = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [5:0]     AN_OFF     = (AN_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t               state, next_state;
  logic [2:0]           idx, next_idx;
  logic [DWELL_W-1:0]   dwell, next_dwell;
  logic [5:0][3:0]      shadow, next_shadow;
  logic [5:0][3:0]      live;
  logic                 snap, snap_bad, next_frame_done;
  logic                 bcd_err, frame_done;
  logic [6:0]           seg_reg, next_seg, raw_seg;
  logic                 dp_reg, next_dp, raw_dp;
  logic [5:0]           an_reg, next_an, raw_an;
  logic [3:0]           cur_digit;

  // Slot 0 is the leftmost digit (hours tens).
  assign live = {bus.secl, bus.secm, bus.minl, bus.minm, bus.hrl, bus.hrm};

  function automatic logic digit_ok(input logic [2:0] pos, input logic [3:0] d);
    case (pos)
      3'd0:       digit_ok = (d <= 4'd2);
      3'd2, 3'd4: digit_ok = (d <= 4'd5);
      default:    digit_ok = (d <= 4'd9);
    endcase
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  // Next-state logic for the scan sequencer and the snapshot.
  always_comb begin
    next_state      = state;
    next_idx        = idx;
    next_dwell      = dwell;
    snap            = 1'b0;
    next_frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en) begin
          next_state = SCAN;
          next_idx   = 3'd0;
          next_dwell = '0;
          snap       = 1'b1;
        end
      end
      default: begin
        if (!bus.en) begin
          next_state = IDLE;
          next_idx   = 3'd0;
          next_dwell = '0;
        end else if (dwell != DWELL_LAST) begin
          next_dwell = dwell + 1'b1;
        end else begin
          next_dwell = '0;
          if (idx != IDX_LAST) begin
            next_idx = idx + 3'd1;
          end else begin
            next_idx        = 3'd0;
            snap            = 1'b1;
            next_frame_done = 1'b1;
          end
        end
      end
    endcase
    next_shadow = snap ? live : shadow;
  end

  always_comb begin
    snap_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!digit_ok(3'(i), live[i])) snap_bad = 1'b1;
    end
  end

  // Display decode from the next state so the registered outputs line up
  // with the state registers.
  always_comb begin
    raw_seg   = 7'h00;
    raw_dp    = 1'b0;
    raw_an    = 6'h00;
    cur_digit = next_shadow[next_idx];
    if (next_state == SCAN) begin
      raw_an = 6'b100000 >> next_idx;
      if (!digit_ok(next_idx, cur_digit)) begin
        raw_seg = SEG_DASH;
      end else if ((next_idx == 3'd0) && bus.lz_blank && (cur_digit == 4'd0)) begin
        raw_seg = 7'h00;
      end else begin
        raw_seg = decode(cur_digit);
      end
      if ((next_idx == 3'd1) || (next_idx == 3'd3)) begin
`ifdef RTC_SEG_BLINK_EN
        raw_dp = ~next_shadow[5][0];
`else
        raw_dp = 1'b1;
`endif
      end
    end
    next_seg = raw_seg ^ SEG_OFF;
    next_dp  = raw_dp ^ DP_OFF;
    next_an  = raw_an ^ AN_OFF;
  end

  always_ff @(posedge hundred_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 3'd0;
      dwell      <= '0;
      shadow     <= '0;
      bcd_err    <= 1'b0;
      frame_done <= 1'b0;
      seg_reg    <= SEG_OFF;
      dp_reg     <= DP_OFF;
      an_reg     <= AN_OFF;
    end else begin
      state      <= next_state;
      idx        <= next_idx;
      dwell      <= next_dwell;
      shadow     <= next_shadow;
      frame_done <= next_frame_done;
      if (snap && snap_bad) bcd_err <= 1'b1;
      seg_reg    <= next_seg;
      dp_reg     <= next_dp;
      an_reg     <= next_an;
    end
  end

  assign bus.seg        = seg_reg;
  assign bus.dp         = dp_reg;
  assign bus.an         = an_reg;
  assign bus.frame_done = frame_done;
  assign bus.bcd_err    = bcd_err;

endmodule
`default_nettype wire
